reg_file_32x32: RTL

//   MIPS general-purpose register file for the single-cycle datapath: 2^ADDR_WIDTH

---
 rtl/reg_file_32x32.sv | 94 +++++++++
 1 files changed

// File: rtl/reg_file_32x32.sv
// reg_file_32x32
//   Register file for the single-cycle MIPS datapath: 2**ADDR_WIDTH registers of
//   DATA_WIDTH bits, two combinational read ports and one synchronous write port.
//   r0 has no storage. Reads of r0 return zero, and writes to r0 are dropped.
//
// Ports
//   clk         in   1           clock, rising edge
//   rst_n       in   1           synchronous reset, active-low; clears r1..rN
//   reg_write   in   1           write enable (RegWrite)
//   read_reg1   in   ADDR_WIDTH  read port 1 index (rs)
//   read_reg2   in   ADDR_WIDTH  read port 2 index (rt)
//   write_reg   in   ADDR_WIDTH  write index (RegDst mux output)
//   write_data  in   DATA_WIDTH  write value (MemtoReg mux output)
//   read_data1  out  DATA_WIDTH  contents of read_reg1
//   read_data2  out  DATA_WIDTH  contents of read_reg2 (feeds the ALUSrc mux)
//
// Configuration
//   WRITE_BYPASS_EN : when defined, a read port whose index matches an active,
//                     non-r0 write returns write_data in the same cycle.
//                     This write-through is suppressed while rst_n is low.
//                     Default: undefined. Reads then show stored state only.
module reg_file_32x32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  // Index 0 is intentionally absent: r0 is hardwired to zero.
  logic [DATA_WIDTH-1:0] regs_q [1:NREGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NREGS-1];

  // Per-entry compare instead of a variable-index store. No entry matches
  // write_reg == 0, so r0 writes fall away. reg_write gates every entry, so X
  // on write_reg or write_data cannot reach state while writes are disabled.
  always_comb begin
    for (int unsigned i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_write && (write_reg == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  logic [DATA_WIDTH-1:0] stored1;
  logic [DATA_WIDTH-1:0] stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (read_reg1 != '0) stored1 = regs_q[read_reg1];
    if (read_reg2 != '0) stored2 = regs_q[read_reg2];
  end

`ifdef WRITE_BYPASS_EN
  logic fwd_active;

  always_comb begin
    fwd_active = reg_write && rst_n && (write_reg != '0);
    read_data1 = stored1;
    read_data2 = stored2;
    if (fwd_active && (write_reg == read_reg1)) read_data1 = write_data;
    if (fwd_active && (write_reg == read_reg2)) read_data2 = write_data;
  end
`else
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
  end
`endif

endmodule
